imm_packer: RTL and testbench

//  Inverse of the immediate sign-extender: takes a 32-bit immediate plus ImmSrc
//  and inserts the immediate into a base instruction word at the RV32I bit positions.

---
 rtl/imm_pkg.sv | 32 +++
 rtl/imm_packer_if.sv | 24 ++
 rtl/imm_pack_comb.sv | 46 ++++
 rtl/imm_packer.sv | 101 ++++++++++
 tb/tb_imm_packer.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/imm_pkg.sv
// Shared immediate-format definitions for the RV32I immediate packer and sign extender.
package imm_pkg;

  typedef logic [2:0] imm_src_t;

  // ImmSrc encodings, shared with sign_ext
  localparam imm_src_t IMM_I = 3'b000;
  localparam imm_src_t IMM_S = 3'b001;
  localparam imm_src_t IMM_B = 3'b010;
  localparam imm_src_t IMM_J = 3'b011;
  localparam imm_src_t IMM_U = 3'b100;

  // Instruction bits occupied by the immediate in each format
  localparam logic [31:0] IMM_FIELD_MASK_I = 32'hFFF0_0000;
  localparam logic [31:0] IMM_FIELD_MASK_S = 32'hFE00_0F80;
  localparam logic [31:0] IMM_FIELD_MASK_B = 32'hFE00_0F80;
  localparam logic [31:0] IMM_FIELD_MASK_J = 32'hFFFF_F000;
  localparam logic [31:0] IMM_FIELD_MASK_U = 32'hFFFF_F000;

  // Illegal formats own no bits, so the base passes through untouched
  function automatic logic [31:0] imm_field_mask(input imm_src_t src);
    case (src)
      IMM_I:   return IMM_FIELD_MASK_I;
      IMM_S:   return IMM_FIELD_MASK_S;
      IMM_B:   return IMM_FIELD_MASK_B;
      IMM_J:   return IMM_FIELD_MASK_J;
      IMM_U:   return IMM_FIELD_MASK_U;
      default: return 32'h0000_0000;
    endcase
  endfunction

endpackage

// File: rtl/imm_packer_if.sv
// Valid/ready stream bundle for imm_packer: input beats and packed output beats.
interface imm_packer_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_base;
  logic [31:0] in_imm;
  logic [2:0]  in_imm_src;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_err;

  // Producer of input beats and consumer of output beats
  modport master (
    output in_valid, in_base, in_imm, in_imm_src, out_ready,
    input  in_ready, out_valid, out_instr, out_err
  );

  // The packer itself
  modport slave (
    input  in_valid, in_base, in_imm, in_imm_src, out_ready,
    output in_ready, out_valid, out_instr, out_err
  );
endinterface

// File: rtl/imm_pack_comb.sv
// Combinational immediate packer: clears the format's immediate bits in base and inserts imm.
// With IMM_RANGE_CHECK_EN defined, also flags non-representable immediates / illegal ImmSrc.
module imm_pack_comb
  import imm_pkg::*;
(
  input  logic [31:0] base,
  input  logic [31:0] imm,
  input  imm_src_t    src,
  output logic [31:0] instr
`ifdef IMM_RANGE_CHECK_EN
  ,
  output logic        err
`endif
);

  logic [31:0] field;

  // Scatter the immediate into its RV32I instruction positions
  always_comb begin
    field = '0;
    case (src)
      IMM_I:   field = {imm[11:0], 20'b0};
      IMM_S:   field = {imm[11:5], 13'b0, imm[4:0], 7'b0};
      IMM_B:   field = {imm[12], imm[10:5], 13'b0, imm[4:1], imm[11], 7'b0};
      IMM_J:   field = {imm[20], imm[10:1], imm[11], imm[19:12], 12'b0};
      IMM_U:   field = {imm[31:12], 12'b0};
      default: field = '0;
    endcase
    instr = (base & ~imm_field_mask(src)) | field;
  end

`ifdef IMM_RANGE_CHECK_EN
  // Immediate is representable when every bit above the field is a copy of the sign bit
  always_comb begin
    err = 1'b1;
    case (src)
      IMM_I, IMM_S: err = !(&imm[31:11] || ~|imm[31:11]);
      IMM_B:        err = !((&imm[31:12] || ~|imm[31:12]) && !imm[0]);
      IMM_J:        err = !((&imm[31:20] || ~|imm[31:20]) && !imm[0]);
      IMM_U:        err = |imm[11:0];
      default:      err = 1'b1;
    endcase
  end
`endif

endmodule

// File: rtl/imm_packer.sv
// Buffered immediate packer: packs each accepted beat and queues it in a DEPTH-entry FIFO.
// Optional macro IMM_RANGE_CHECK_EN adds per-entry range-error flags and a saturating
// error counter; without it out_err and err_cnt are constant zero.
module imm_packer
  import imm_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  imm_packer_if.slave      bus,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int unsigned   PTR_W    = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [31:0]      pack_instr;
  logic             push;
  logic             pop;
  logic [31:0]      instr_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W:0]   count_q;

`ifdef IMM_RANGE_CHECK_EN
  logic             pack_err;
  logic             err_q [DEPTH];
  logic [CNT_W-1:0] err_cnt_q;
`endif

  imm_pack_comb u_pack (
    .base  (bus.in_base),
    .imm   (bus.in_imm),
    .src   (bus.in_imm_src),
    .instr (pack_instr)
`ifdef IMM_RANGE_CHECK_EN
    ,
    .err   (pack_err)
`endif
  );

  // in_ready depends only on registered occupancy, never on out_ready
  assign bus.in_ready  = (count_q != FULL_CNT);
  assign bus.out_valid = (count_q != '0);
  assign push          = bus.in_valid && bus.in_ready;
  assign pop           = bus.out_valid && bus.out_ready;
  assign bus.out_instr = instr_q[rd_ptr_q];

  // FIFO storage, pointers (wrap at power-of-two DEPTH) and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        instr_q[i] <= '0;
      end
    end else begin
      if (push) begin
        instr_q[wr_ptr_q] <= pack_instr;
        wr_ptr_q          <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + (PTR_W + 1)'(1);
        2'b01:   count_q <= count_q - (PTR_W + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

`ifdef IMM_RANGE_CHECK_EN
  // Per-entry error flag and accept-time saturating error count
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        err_q[i] <= 1'b0;
      end
    end else begin
      if (push) begin
        err_q[wr_ptr_q] <= pack_err;
      end
      if (push && pack_err && (err_cnt_q != '1)) begin
        err_cnt_q <= err_cnt_q + CNT_W'(1);
      end
    end
  end

  assign bus.out_err = err_q[rd_ptr_q];
  assign err_cnt     = err_cnt_q;
`else
  assign bus.out_err = 1'b0;
  assign err_cnt     = '0;
`endif

endmodule

// File: tb/tb_imm_packer.sv
// Self-checking bench for imm_packer: directed vector table, backpressure and reset
// sequences, and randomized traffic against a bit-placement model plus decode round-trip.
module tb_imm_packer;
  import imm_pkg::*;

  localparam int unsigned DEPTH = 2;
  localparam int unsigned CNT_W = 3;
`ifdef IMM_RANGE_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [CNT_W-1:0] err_cnt;

  imm_packer_if bus ();

  imm_packer #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .err_cnt (err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic        err;
    logic [31:0] imm;
    logic [2:0]  src;
    bit          repr;
  } exp_t;

  typedef struct {
    logic [2:0]  src;
    logic [31:0] base;
    logic [31:0] imm;
    logic [31:0] instr;
    logic        err;
  } vec_t;

  int          total = 0;
  int          bad = 0;
  exp_t        q[$];
  int          model_cnt = 0;
  bit          stall_prev = 0;
  logic [31:0] stall_instr;
  logic        stall_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Copy imm[vlo +: hi-lo+1] into w[hi:lo]
  function automatic logic [31:0] put(input logic [31:0] w, input int hi, input int lo,
                                      input logic [31:0] v, input int vlo);
    for (int i = lo; i <= hi; i++) w[i] = v[vlo + i - lo];
    return w;
  endfunction

  function automatic logic [31:0] model_pack(input logic [2:0] src, input logic [31:0] base,
                                             input logic [31:0] imm);
    logic [31:0] r = base;
    case (src)
      3'd0: r = put(r, 31, 20, imm, 0);
      3'd1: begin r = put(r, 31, 25, imm, 5); r = put(r, 11, 7, imm, 0); end
      3'd2: begin
        r = put(r, 31, 31, imm, 12); r = put(r, 30, 25, imm, 5);
        r = put(r, 11, 8, imm, 1);   r = put(r, 7, 7, imm, 11);
      end
      3'd3: begin
        r = put(r, 31, 31, imm, 20); r = put(r, 30, 21, imm, 1);
        r = put(r, 20, 20, imm, 11); r = put(r, 19, 12, imm, 12);
      end
      3'd4: r = put(r, 31, 12, imm, 12);
      default: ;
    endcase
    return r;
  endfunction

  // RV32I immediate decode (the sign extender this block inverts)
  function automatic logic [31:0] model_sext(input logic [2:0] src, input logic [31:0] in);
    case (src)
      3'd0: return {{20{in[31]}}, in[31:20]};
      3'd1: return {{20{in[31]}}, in[31:25], in[11:7]};
      3'd2: return {{19{in[31]}}, in[31], in[7], in[30:25], in[11:8], 1'b0};
      3'd3: return {{11{in[31]}}, in[31], in[19:12], in[20], in[30:21], 1'b0};
      3'd4: return {in[31:12], 12'b0};
      default: return 32'h0;
    endcase
  endfunction

  function automatic bit model_repr(input logic [2:0] src, input logic [31:0] imm);
    int s = $signed(imm);
    case (src)
      3'd0, 3'd1: return (s >= -2048) && (s <= 2047);
      3'd2:       return (s >= -4096) && (s <= 4095) && (s % 2 == 0);
      3'd3:       return (s >= -(1 << 20)) && (s < (1 << 20)) && (s % 2 == 0);
      3'd4:       return (imm % 4096) == 0;
      default:    return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] rand_imm(input logic [2:0] src, input bit want_repr);
    int v;
    if (!want_repr) return $urandom;
    case (src)
      3'd0, 3'd1: begin v = int'($urandom_range(0, 4095)) - 2048; return 32'(v); end
      3'd2:       begin v = int'($urandom_range(0, 4095)) - 2048; return 32'(v * 2); end
      3'd3: begin v = int'($urandom_range(0, 1048575)) - 524288; return 32'(v * 2); end
      3'd4:       return $urandom & 32'hFFFF_F000;
      default:    return $urandom;
    endcase
  endfunction

  // One clock cycle: drive, check outputs against the scoreboard, track handshakes
  task automatic step(input logic v, input logic [2:0] src, input logic [31:0] base,
                      input logic [31:0] imm, input logic [31:0] e_instr, input logic e_err,
                      input logic ordy, output logic acc);
    exp_t e;
    bus.in_valid   = v;
    bus.in_imm_src = src;
    bus.in_base    = base;
    bus.in_imm     = imm;
    bus.out_ready  = ordy;
    @(negedge clk);
    check("in_ready", 32'(bus.in_ready), 32'(q.size() < DEPTH));
    check("out_valid", 32'(bus.out_valid), 32'(q.size() != 0));
    check("err_cnt", 32'(err_cnt), 32'(model_cnt));
    if (stall_prev) begin
      check("stall_instr", bus.out_instr, stall_instr);
      check("stall_err", 32'(bus.out_err), 32'(stall_err));
    end
    stall_prev  = bus.out_valid && !ordy;
    stall_instr = bus.out_instr;
    stall_err   = bus.out_err;
    if (bus.out_valid && ordy && q.size() != 0) begin
      e = q.pop_front();
      check("out_instr", bus.out_instr, e.instr);
      check("out_err", 32'(bus.out_err), 32'(e.err));
      if (e.repr) check("round_trip", model_sext(e.src, bus.out_instr), e.imm);
    end
    acc = v && bus.in_ready;
    if (acc) begin
      e.instr = e_instr;
      e.err   = CHK ? e_err : 1'b0;
      e.imm   = imm;
      e.src   = src;
      e.repr  = model_repr(src, imm);
      q.push_back(e);
      if (e.err && model_cnt < (1 << CNT_W) - 1) model_cnt++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic model_beat(input logic v, input logic [2:0] src, input logic [31:0] base,
                            input logic [31:0] imm, input logic ordy, output logic acc);
    step(v, src, base, imm, model_pack(src, base, imm), !model_repr(src, imm), ordy, acc);
  endtask

  task automatic drain();
    logic acc;
    for (int i = 0; i < 6; i++) step(1'b0, 3'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, acc);
  endtask

  vec_t        vt[10];
  logic        acc;
  logic [2:0]  src;
  logic [31:0] imm;
  logic [31:0] base;

  initial begin
    vt[0] = '{3'd0, 32'h0000_0013, 32'hFFFF_FFFF, 32'hFFF0_0013, 1'b0};
    vt[1] = '{3'd2, 32'h0000_0063, 32'h0000_0FFE, 32'h7E00_0FE3, 1'b0};
    vt[2] = '{3'd3, 32'h0000_006F, 32'h0000_0801, 32'h0010_006F, 1'b1};
    vt[3] = '{3'd4, 32'h0000_0037, 32'h1234_5678, 32'h1234_5037, 1'b1};
    vt[4] = '{3'd7, 32'h1234_5678, 32'hDEAD_BEEF, 32'h1234_5678, 1'b1};
    vt[5] = '{3'd1, 32'h0000_2023, 32'hFFFF_FFFC, 32'hFE00_2E23, 1'b0};
    vt[6] = '{3'd0, 32'hFFFF_FFFF, 32'h0000_0000, 32'h000F_FFFF, 1'b0};
    vt[7] = '{3'd0, 32'h0000_0013, 32'h0000_0800, 32'h8000_0013, 1'b1};
    vt[8] = '{3'd5, 32'h00A0_0093, 32'h0000_0000, 32'h00A0_0093, 1'b1};
    vt[9] = '{3'd3, 32'h0000_006F, 32'hFFFF_FFFE, 32'hFFFF_F06F, 1'b0};

    bus.in_valid   = 1'b0;
    bus.in_imm_src = 3'd0;
    bus.in_base    = 32'h0;
    bus.in_imm     = 32'h0;
    bus.out_ready  = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_instr", bus.out_instr, 32'h0);
    check("rst_out_err", 32'(bus.out_err), 32'd0);
    check("rst_err_cnt", 32'(err_cnt), 32'd0);
    @(posedge clk);
    #1;

    // Directed vectors, one beat at a time with out_ready held high
    for (int i = 0; i < 10; i++) begin
      acc = 1'b0;
      for (int t = 0; t < 8 && !acc; t++)
        step(1'b1, vt[i].src, vt[i].base, vt[i].imm, vt[i].instr, vt[i].err, 1'b1, acc);
      check("tbl_accept", 32'(acc), 32'd1);
      step(1'b0, 3'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, acc);
    end
    drain();

    // Backpressure: third beat blocked while full, then all three drain in order
    model_beat(1'b1, 3'd0, 32'h0000_0013, 32'd1, 1'b0, acc);
    check("bp_acc0", 32'(acc), 32'd1);
    model_beat(1'b1, 3'd0, 32'h0000_0013, 32'd2, 1'b0, acc);
    check("bp_acc1", 32'(acc), 32'd1);
    model_beat(1'b1, 3'd0, 32'h0000_0013, 32'd3, 1'b0, acc);
    check("bp_full_block", 32'(acc), 32'd0);
    model_beat(1'b1, 3'd0, 32'h0000_0013, 32'd3, 1'b0, acc);
    check("bp_full_hold", 32'(acc), 32'd0);
    acc = 1'b0;
    for (int t = 0; t < 8 && !acc; t++)
      model_beat(1'b1, 3'd0, 32'h0000_0013, 32'd3, 1'b1, acc);
    check("bp_acc2", 32'(acc), 32'd1);
    drain();
    check("bp_empty", 32'(q.size()), 32'd0);

    // Error burst to exercise counter saturation
    for (int i = 0; i < 10; i++) model_beat(1'b1, 3'd6, $urandom, $urandom, 1'b1, acc);
    drain();

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      src  = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 4)) : 3'($urandom_range(5, 7));
      imm  = rand_imm(src, $urandom_range(0, 1) == 1);
      base = $urandom;
      model_beat($urandom_range(0, 9) < 7, src, base, imm, $urandom_range(0, 9) < 6, acc);
    end
    drain();

    // Reset while full drops everything in flight
    model_beat(1'b1, 3'd7, 32'h1, 32'h0, 1'b0, acc);
    model_beat(1'b1, 3'd4, 32'h2, 32'h5, 1'b0, acc);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst2_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst2_err_cnt", 32'(err_cnt), 32'd0);
    check("rst2_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst2_out_instr", bus.out_instr, 32'h0);
    q.delete();
    model_cnt  = 0;
    stall_prev = 0;
    @(posedge clk);
    #1;
    model_beat(1'b1, 3'd2, 32'h0000_0063, 32'h0000_0FFE, 1'b1, acc);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
